// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, port indices, starve counter width.
// Imported by the interface-level top and the pick sub-module.
package sdram_arb_pkg;

  localparam int NUM_PORTS = 3;
  localparam int STARVE_W  = 4;

  localparam logic [1:0] P_VIDEO = 2'd0;
  localparam logic [1:0] P_CPU   = 2'd1;
  localparam logic [1:0] P_DMA   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] p);
    return NUM_PORTS'(1) << p;
  endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Bundles the three master request ports and the SDRAM controller command port.
// Port N of each packed array belongs to master N (0 video, 1 CPU, 2 DMA).
interface sdram_arb_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic [2:0]                   req;
  logic [2:0][ADDR_W-1:0]       addr;
  logic [2:0]                   wr;
  logic [2:0][DATA_W-1:0]       wdata;
  logic [2:0][DATA_W/8-1:0]     bytesel;
  logic [2:0]                   ack;
  logic [DATA_W-1:0]            rdata;

  logic                         ctl_req;
  logic [ADDR_W-1:0]            ctl_addr;
  logic                         ctl_wr;
  logic [DATA_W-1:0]            ctl_wdata;
  logic [DATA_W/8-1:0]          ctl_bytesel;
  logic                         ctl_ack;
  logic                         ctl_rdvalid;
  logic [DATA_W-1:0]            ctl_rdata;

  modport slave (
    input  req, addr, wr, wdata, bytesel, ctl_ack, ctl_rdvalid, ctl_rdata,
    output ack, rdata, ctl_req, ctl_addr, ctl_wr, ctl_wdata, ctl_bytesel
  );

  modport master (
    output req, addr, wr, wdata, bytesel, ctl_ack, ctl_rdvalid, ctl_rdata,
    input  ack, rdata, ctl_req, ctl_addr, ctl_wr, ctl_wdata, ctl_bytesel
  );
endinterface

// File: rtl/sdram_arb_pick.sv
// Winner select: video first unless it has starved CPU/DMA for STARVE_LIMIT grants; CPU/DMA round-robin.
// Combinational pick; rr pointer and starve count advance only on the update strobe.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic [2:0] req,
  input  logic       update,
  output logic [1:0] winner,
  output logic       any_req
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q;
  logic                rr_dma_q;   // 1: DMA has round-robin precedence
  logic                others;

  always_comb begin
    others  = req[P_CPU] | req[P_DMA];
    any_req = |req;
    winner  = P_VIDEO;
    if (req[P_VIDEO] && ((starve_q < LIMIT) || !others)) begin
      winner = P_VIDEO;
    end else if (rr_dma_q) begin
      winner = req[P_DMA] ? P_DMA : P_CPU;
    end else begin
      winner = req[P_CPU] ? P_CPU : P_DMA;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      starve_q <= '0;
      rr_dma_q <= 1'b0;
    end else begin
      if (!others) begin
        starve_q <= '0;
      end else if (update) begin
        if (winner == P_VIDEO) begin
          if (starve_q < LIMIT) starve_q <= starve_q + STARVE_W'(1);
        end else begin
          starve_q <= '0;
        end
      end
      if (update && (winner != P_VIDEO)) rr_dma_q <= (winner == P_CPU);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port among video/CPU/DMA masters, one transaction outstanding.
// Write ack 1 cycle after ctl_ack, read ack 1 cycle after ctl_rdvalid; masters wait on level req until ack.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset_in,
  sdram_arb_if.slave bus,
  output logic [1:0] grant,
  output logic       busy
);

  state_t state_q, state_d;

  logic [1:0] winner;
  logic       any_req;
  logic       pick_en;
  logic       issue_done;
  logic       rd_done;
  logic       ack_fire;

  logic                  ctl_req_q;
  logic [ADDR_W-1:0]     ctl_addr_q;
  logic                  ctl_wr_q;
  logic [DATA_W-1:0]     ctl_wdata_q;
  logic [DATA_W/8-1:0]   ctl_bytesel_q;
  logic [NUM_PORTS-1:0]  ack_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [1:0]            grant_q;

  sdram_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk     (clk),
    .reset_in(reset_in),
    .req     (bus.req),
    .update  (pick_en),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pick_en    = 1'b0;
    issue_done = 1'b0;
    rd_done    = 1'b0;
    ack_fire   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          pick_en = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.ctl_ack) begin
          issue_done = 1'b1;
          if (ctl_wr_q) begin
            ack_fire = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        if (bus.ctl_rdvalid) begin
          rd_done  = 1'b1;
          ack_fire = 1'b1;
          state_d  = ST_DONE;
        end
      end
      // Dead cycle so registered masters can drop req before the next pick.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // grant_q doubles as the latched winner that receives the ack.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      ctl_req_q     <= 1'b0;
      ctl_addr_q    <= '0;
      ctl_wr_q      <= 1'b0;
      ctl_wdata_q   <= '0;
      ctl_bytesel_q <= '0;
      ack_q         <= '0;
      rdata_q       <= '0;
      grant_q       <= '0;
    end else begin
      ack_q <= '0;
      if (pick_en) begin
        ctl_req_q     <= 1'b1;
        ctl_addr_q    <= bus.addr[winner];
        ctl_wr_q      <= bus.wr[winner];
        ctl_wdata_q   <= bus.wdata[winner];
        ctl_bytesel_q <= bus.bytesel[winner];
        grant_q       <= winner;
      end
      if (issue_done) ctl_req_q <= 1'b0;
      if (ack_fire)   ack_q     <= port_onehot(grant_q);
      if (rd_done)    rdata_q   <= bus.ctl_rdata;
    end
  end

  assign bus.ctl_req     = ctl_req_q;
  assign bus.ctl_addr    = ctl_addr_q;
  assign bus.ctl_wr      = ctl_wr_q;
  assign bus.ctl_wdata   = ctl_wdata_q;
  assign bus.ctl_bytesel = ctl_bytesel_q;
  assign bus.ack         = ack_q;
  assign bus.rdata       = rdata_q;
  assign grant           = grant_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Random masters and controller against a transaction-level arbiter model.
// Directed phases cover starvation order, reset-time order and reset during a read.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int LIMIT  = 4;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic [1:0] grant;
  logic       busy;

  sdram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .reset_in(reset_in),
    .bus     (bus.slave),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs (percent per cycle)
  int unsigned raise_pct [3];
  int unsigned hold_pct  [3];
  int unsigned ack_pct;
  int unsigned rdv_pct;
  logic [2:0]  ack_s;

  task automatic new_fields(input int p);
    bus.addr[p]    = ADDR_W'($urandom);
    bus.wr[p]      = 1'($urandom_range(1));
    bus.wdata[p]   = $urandom;
    bus.bytesel[p] = BE_W'($urandom);
  endtask

  // Registered masters and a randomly acking controller, driven just after each edge.
  initial begin
    bus.req = '0; bus.addr = '0; bus.wr = '0; bus.wdata = '0; bus.bytesel = '0;
    bus.ctl_ack = 1'b0; bus.ctl_rdvalid = 1'b0; bus.ctl_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 3; p++) begin
        if (bus.req[p]) begin
          if (ack_s[p]) begin
            if ($urandom_range(99) < hold_pct[p]) new_fields(p);
            else bus.req[p] = 1'b0;
          end
        end else if ($urandom_range(99) < raise_pct[p]) begin
          new_fields(p);
          bus.req[p] = 1'b1;
        end
      end
      bus.ctl_ack     = ($urandom_range(99) < ack_pct);
      bus.ctl_rdvalid = ($urandom_range(99) < rdv_pct);
      bus.ctl_rdata   = $urandom;
    end
  end

  // Reference model: transaction phases tracked as flags, arbitration from the priority rules.
  bit   free, issuing, waiting;
  int   gap, starve, ptr, win, w;
  logic [1:0]            exp_grant;
  logic [DATA_W-1:0]     exp_rdata;
  logic [2:0]            exp_ack;
  logic [ADDR_W-1:0]     e_addr;
  logic                  e_wr;
  logic [DATA_W-1:0]     e_wd;
  logic [BE_W-1:0]       e_be;
  logic [2:0]            preq;
  logic                  pctl_ack, prdv, p12;
  logic [DATA_W-1:0]     prdata;
  logic [2:0][ADDR_W-1:0] paddr;
  logic [2:0]            pwr;
  logic [2:0][DATA_W-1:0] pwd;
  logic [2:0][BE_W-1:0]  pbe;
  int   grant_log [$];

  task automatic model_reset();
    free = 1'b1; issuing = 1'b0; waiting = 1'b0; gap = 0;
    starve = 0; ptr = 1; win = 0;
    exp_grant = '0; exp_rdata = '0;
    e_addr = '0; e_wr = 1'b0; e_wd = '0; e_be = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset_in) begin
        model_reset();
        ack_s = '0;
      end else begin
        exp_ack = '0;
        if (issuing && pctl_ack) begin
          issuing = 1'b0;
          if (e_wr) begin exp_ack = 3'b001 << win; gap = 1; end
          else waiting = 1'b1;
        end else if (waiting && prdv) begin
          waiting   = 1'b0;
          exp_rdata = prdata;
          exp_ack   = 3'b001 << win;
          gap       = 1;
        end else if (free && (preq != 3'b000)) begin
          p12 = preq[1] | preq[2];
          if (preq[0] && ((starve < LIMIT) || !p12)) w = 0;
          else if (preq[ptr]) w = ptr;
          else w = 3 - ptr;
          if (w == 0) starve = p12 ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
          else begin starve = 0; ptr = 3 - w; end
          win = w; exp_grant = 2'(w);
          e_addr = paddr[w]; e_wr = pwr[w]; e_wd = pwd[w]; e_be = pbe[w];
          free = 1'b0; issuing = 1'b1;
          grant_log.push_back(int'(grant));
        end else if (gap > 0) begin
          gap  = 0;
          free = 1'b1;
        end
        if (!(preq[1] | preq[2])) starve = 0;

        check_eq("ack", bus.ack, exp_ack);
        check_eq("ctl_req", bus.ctl_req, issuing);
        check_eq("busy", busy, !free);
        check_eq("grant", grant, exp_grant);
        check_eq("rdata", bus.rdata, exp_rdata);
        if (issuing)
          check_eq("ctl_fields", {bus.ctl_addr, bus.ctl_wr, bus.ctl_wdata, bus.ctl_bytesel},
                   {e_addr, e_wr, e_wd, e_be});
        ack_s = bus.ack;
      end
      preq = bus.req; pctl_ack = bus.ctl_ack; prdv = bus.ctl_rdvalid; prdata = bus.ctl_rdata;
      paddr = bus.addr; pwr = bus.wr; pwd = bus.wdata; pbe = bus.bytesel;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ack"}, bus.ack, 3'b000);
    check_eq({tag, "_ctl_req"}, bus.ctl_req, 1'b0);
    check_eq({tag, "_ctl_addr"}, bus.ctl_addr, '0);
    check_eq({tag, "_ctl_wr"}, bus.ctl_wr, 1'b0);
    check_eq({tag, "_ctl_wdata"}, bus.ctl_wdata, '0);
    check_eq({tag, "_ctl_bytesel"}, bus.ctl_bytesel, '0);
    check_eq({tag, "_rdata"}, bus.rdata, '0);
    check_eq({tag, "_grant"}, grant, 2'b00);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic restart(input int unsigned r0, input int unsigned r1, input int unsigned r2);
    reset_in = 1'b0;
    raise_pct = '{r0, r1, r2};
    repeat (3) @(posedge clk);
    grant_log.delete();
    @(negedge clk);
    #1 reset_in = 1'b1;
  endtask

  int pat3 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int pat4 [3]  = '{0, 1, 2};
  int n;

  initial begin
    raise_pct = '{0, 0, 0}; hold_pct = '{0, 0, 0}; ack_pct = 50; rdv_pct = 30;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");

    // Video and CPU both held: four video grants, then one CPU grant.
    hold_pct = '{100, 100, 0};
    restart(100, 100, 0);
    repeat (300) @(posedge clk);
    check_eq("starve_count", grant_log.size() >= 10, 1'b1);
    for (int i = 0; i < 10; i++)
      if (i < grant_log.size()) check_eq("starve_seq", grant_log[i], pat3[i]);

    // All three requesting out of reset; each drops after its ack.
    hold_pct = '{0, 0, 0};
    restart(100, 100, 100);
    raise_pct = '{0, 0, 0};
    repeat (200) @(posedge clk);
    check_eq("reset_order_count", grant_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < grant_log.size()) check_eq("reset_order", grant_log[i], pat4[i]);

    // Reset while a read waits for data, then late rdvalid pulses.
    hold_pct = '{50, 50, 50};
    for (int k = 0; k < 3; k++) begin
      raise_pct = '{40, 40, 40}; ack_pct = 40; rdv_pct = 10;
      n = 0;
      while (!waiting && n < 1000) begin
        @(negedge clk);
        #1 n++;
      end
      check_eq("wait_rd_reached", waiting, 1'b1);
      reset_in = 1'b0;
      #1 check_outputs_zero("async_reset");
      rdv_pct = 100;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 reset_in = 1'b1;
      repeat (4) @(posedge clk);
      rdv_pct = 20;
      repeat (500) @(posedge clk);
    end

    // Slow controller acks with frequent spurious rdvalid pulses.
    raise_pct = '{30, 50, 50}; hold_pct = '{30, 60, 60}; ack_pct = 8; rdv_pct = 50;
    repeat (2000) @(posedge clk);

    // Heavy mixed traffic.
    raise_pct = '{70, 60, 60}; hold_pct = '{80, 70, 70}; ack_pct = 60; rdv_pct = 40;
    repeat (3000) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
